// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/interrupt controller: load-use stalls, redirect flushes, RET drain and interrupt entry.
// Zero-cycle combinational controls from registered state; stall_cnt saturates at 255.
module pipe_hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] id_ra,
    input  logic [1:0] id_rb,
    input  logic       id_uses_ra,
    input  logic       id_uses_rb,
    input  logic       id_is_ret,
    input  logic       ex_MemRead,
    input  logic       ex_RegWrite,
    input  logic [1:0] ex_rd,
    input  logic       ex_branch_taken,
    input  logic       irq,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       id_ex_bubble,
    output logic       int_signal,
    output logic [2:0] state_o,
    output logic [7:0] stall_cnt
);

    typedef enum logic [2:0] {
        S_RUN       = 3'd0,
        S_RET_WAIT  = 3'd1,
        S_INT_ENTRY = 3'd2,
        S_INT_DRAIN = 3'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_wait_cnt;
    logic [1:0] w_wait_nxt;
    logic [1:0] w_wait_dec;
    logic       r_irq_d;
    logic       r_irq_pend;
    logic       w_irq_rise;
    logic       w_irq_clr;
    logic       w_load_use;
    logic       w_ra_hit;
    logic       w_rb_hit;
    logic [7:0] r_stall_cnt;

    assign w_ra_hit   = id_uses_ra && (id_ra == ex_rd);
    assign w_rb_hit   = id_uses_rb && (id_rb == ex_rd);
    assign w_load_use = ex_MemRead && ex_RegWrite && (w_ra_hit || w_rb_hit);
    assign w_irq_rise = irq && !r_irq_d;
    assign w_irq_clr  = (r_state == S_INT_ENTRY);
    assign w_wait_dec = (r_wait_cnt == 2'd0) ? 2'd0 : (r_wait_cnt - 2'd1);

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        int_signal   = 1'b0;
        w_state_nxt  = r_state;
        w_wait_nxt   = r_wait_cnt;
        if (!rst) begin
            case (r_state)
                S_RUN: begin
                    if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (r_irq_pend && !id_is_ret) begin
                        pc_stall    = 1'b1;
                        if_id_flush = 1'b1;
                        w_state_nxt = S_INT_ENTRY;
                    end else if (w_load_use) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (id_is_ret) begin
                        pc_stall    = 1'b1;
                        w_wait_nxt  = 2'd2;
                        w_state_nxt = S_RET_WAIT;
                    end
                end
                S_RET_WAIT: begin
                    pc_stall    = 1'b1;
                    if_id_flush = 1'b1;
                    w_wait_nxt  = w_wait_dec;
                    if (ex_branch_taken) begin
                        id_ex_flush = 1'b1;
                        w_state_nxt = S_RUN;
                    end else if (r_wait_cnt == 2'd0) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_INT_ENTRY: begin
                    int_signal  = 1'b1;
                    pc_stall    = 1'b1;
                    if_id_flush = 1'b1;
                    w_wait_nxt  = 2'd1;
                    w_state_nxt = S_INT_DRAIN;
                end
                S_INT_DRAIN: begin
                    pc_stall   = 1'b1;
                    w_wait_nxt = w_wait_dec;
                    // A redirect flushes ID/EX, which takes precedence over the bubble.
                    if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else begin
                        id_ex_bubble = 1'b1;
                    end
                    if (r_wait_cnt == 2'd0) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                    w_state_nxt = S_RUN;
                    w_wait_nxt  = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_wait_cnt  <= 2'd0;
            r_irq_d     <= 1'b0;
            r_irq_pend  <= 1'b0;
            r_stall_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_irq_d    <= irq;
            // Leaving INT_ENTRY consumes the request even if a new edge lands that cycle.
            if (w_irq_clr) begin
                r_irq_pend <= 1'b0;
            end else if (w_irq_rise) begin
                r_irq_pend <= 1'b1;
            end
            if (pc_stall && (r_stall_cnt != 8'hFF)) begin
                r_stall_cnt <= r_stall_cnt + 8'd1;
            end
        end
    end

    assign state_o   = r_state;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized run against a reference model.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] id_ra, id_rb, ex_rd;
    logic       id_uses_ra, id_uses_rb, id_is_ret;
    logic       ex_MemRead, ex_RegWrite, ex_branch_taken, irq;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_flush, id_ex_bubble, int_signal;
    logic [2:0] state_o;
    logic [7:0] stall_cnt;
    logic [5:0] dut_ctrl;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode number, cycles still to spend in a wait mode, pending irq, stall count.
    int         m_mode = 0;
    int         m_left = 0;
    int         m_nmode, m_nleft;
    bit         m_pend = 0;
    bit         m_irq_prev = 0;
    int         m_cnt = 0;
    logic [5:0] m_ctrl;

    always #5 clk = ~clk;

    assign dut_ctrl = {pc_stall, if_id_stall, if_id_flush, id_ex_flush, id_ex_bubble, int_signal};

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_ra(id_ra), .id_rb(id_rb), .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb),
        .id_is_ret(id_is_ret), .ex_MemRead(ex_MemRead), .ex_RegWrite(ex_RegWrite),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .irq(irq),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .id_ex_bubble(id_ex_bubble), .int_signal(int_signal),
        .state_o(state_o), .stall_cnt(stall_cnt)
    );

    task automatic model_eval();
        bit lu;
        lu = ex_MemRead && ex_RegWrite &&
             ((id_uses_ra && id_ra == ex_rd) || (id_uses_rb && id_rb == ex_rd));
        m_ctrl  = 6'b000000;
        m_nmode = m_mode;
        m_nleft = m_left;
        if (!rst) begin
            case (m_mode)
                0: begin
                    if (ex_branch_taken) m_ctrl = 6'b001100;
                    else if (m_pend && !id_is_ret) begin m_ctrl = 6'b101000; m_nmode = 2; end
                    else if (lu) m_ctrl = 6'b110010;
                    else if (id_is_ret) begin m_ctrl = 6'b100000; m_nmode = 1; m_nleft = 3; end
                end
                1: begin
                    if (ex_branch_taken) begin m_ctrl = 6'b101100; m_nmode = 0; end
                    else begin
                        m_ctrl = 6'b101000;
                        m_nleft = m_left - 1;
                        if (m_nleft == 0) m_nmode = 0;
                    end
                end
                2: begin m_ctrl = 6'b101001; m_nmode = 3; m_nleft = 2; end
                default: begin
                    m_ctrl = ex_branch_taken ? 6'b101100 : 6'b100010;
                    m_nleft = m_left - 1;
                    if (m_nleft == 0) m_nmode = 0;
                end
            endcase
        end
    endtask

    task automatic model_commit();
        if (rst) begin
            m_mode = 0; m_left = 0; m_pend = 0; m_irq_prev = 0; m_cnt = 0;
        end else begin
            if (m_mode == 2) m_pend = 0;
            else if (irq && !m_irq_prev) m_pend = 1;
            m_irq_prev = irq;
            if (m_ctrl[5] && m_cnt < 255) m_cnt = m_cnt + 1;
            m_mode = m_nmode;
            m_left = m_nleft;
        end
    endtask

    task automatic eval();
        #3;
        model_eval();
    endtask

    task automatic adv();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic clr_in();
        id_ra = 2'd0; id_rb = 2'd0; ex_rd = 2'd0;
        id_uses_ra = 1'b0; id_uses_rb = 1'b0; id_is_ret = 1'b0;
        ex_MemRead = 1'b0; ex_RegWrite = 1'b0; ex_branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq = 1'b0;
        id_is_ret = 1'b1; ex_branch_taken = 1'b1; ex_MemRead = 1'b1; ex_RegWrite = 1'b1;
        id_uses_ra = 1'b1;
        eval();
        n_tests++;
        if (dut_ctrl !== 6'b000000) begin
            n_fail++; $display("FAIL reset_ctrl_forced: ctrl=%b expected=000000", dut_ctrl);
        end
        adv();
        clr_in();
        eval();
        n_tests++;
        if (state_o !== 3'd0 || stall_cnt !== 8'd0) begin
            n_fail++; $display("FAIL reset_state: state=%0d cnt=%0d expected 0/0", state_o, stall_cnt);
        end
        adv();
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        logic [10:0] tbl [6];
        logic [10:0] row;
        logic        exp;
        int          cnt;
        tbl[0] = 11'b1_1_10_0_00_1_10_1;
        tbl[1] = 11'b1_1_11_1_11_0_00_1;
        tbl[2] = 11'b1_1_01_0_01_1_00_0;
        tbl[3] = 11'b0_1_10_1_10_1_10_0;
        tbl[4] = 11'b1_0_10_1_10_1_10_0;
        tbl[5] = 11'b1_1_00_1_01_1_11_0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            row = tbl[i];
            {ex_MemRead, ex_RegWrite, ex_rd, id_uses_ra, id_ra, id_uses_rb, id_rb, exp} = row;
            eval();
            n_tests++;
            if (dut_ctrl !== (exp ? 6'b110010 : 6'b000000) || state_o !== 3'd0 || stall_cnt !== 8'(cnt)) begin
                n_fail++;
                $display("FAIL load_use[%0d]: ctrl=%b state=%0d cnt=%0d expected ctrl=%b state=0 cnt=%0d",
                         i, dut_ctrl, state_o, stall_cnt, exp ? 6'b110010 : 6'b000000, cnt);
            end
            if (exp) cnt++;
            adv();
        end
        clr_in();
    endtask

    task automatic test_branch_priority();
        ex_MemRead = 1'b1; ex_RegWrite = 1'b1; ex_rd = 2'd2; id_uses_rb = 1'b1; id_rb = 2'd2;
        ex_branch_taken = 1'b1; id_is_ret = 1'b1;
        eval();
        n_tests++;
        if (dut_ctrl !== 6'b001100 || state_o !== 3'd0) begin
            n_fail++; $display("FAIL branch_over_loaduse: ctrl=%b state=%0d expected 001100/0", dut_ctrl, state_o);
        end
        adv();
        clr_in();
        eval();
        n_tests++;
        if (state_o !== 3'd0 || dut_ctrl !== 6'b000000) begin
            n_fail++; $display("FAIL branch_stays_run: ctrl=%b state=%0d expected 000000/0", dut_ctrl, state_o);
        end
        adv();
    endtask

    task automatic test_ret();
        id_is_ret = 1'b1;
        eval();
        n_tests++;
        if (dut_ctrl !== 6'b100000 || state_o !== 3'd0) begin
            n_fail++; $display("FAIL ret_issue: ctrl=%b state=%0d expected 100000/0", dut_ctrl, state_o);
        end
        adv();
        clr_in();
        for (int k = 0; k < 3; k++) begin
            eval();
            n_tests++;
            if (dut_ctrl !== 6'b101000 || state_o !== 3'd1) begin
                n_fail++; $display("FAIL ret_wait[%0d]: ctrl=%b state=%0d expected 101000/1", k, dut_ctrl, state_o);
            end
            adv();
        end
        eval();
        n_tests++;
        if (dut_ctrl !== 6'b000000 || state_o !== 3'd0) begin
            n_fail++; $display("FAIL ret_done: ctrl=%b state=%0d expected 000000/0", dut_ctrl, state_o);
        end
        adv();
        id_is_ret = 1'b1;
        eval(); adv();
        clr_in();
        eval(); adv();
        ex_branch_taken = 1'b1;
        eval();
        n_tests++;
        if (dut_ctrl !== 6'b101100 || state_o !== 3'd1) begin
            n_fail++; $display("FAIL ret_branch: ctrl=%b state=%0d expected 101100/1", dut_ctrl, state_o);
        end
        adv();
        clr_in();
        eval();
        n_tests++;
        if (dut_ctrl !== 6'b000000 || state_o !== 3'd0) begin
            n_fail++; $display("FAIL ret_branch_exit: ctrl=%b state=%0d expected 000000/0", dut_ctrl, state_o);
        end
        adv();
    endtask

    task automatic test_interrupt();
        logic [2:0] es [6];
        logic [5:0] ec [6];
        es = '{3'd0, 3'd0, 3'd2, 3'd3, 3'd3, 3'd0};
        ec = '{6'b000000, 6'b101000, 6'b101001, 6'b100010, 6'b100010, 6'b000000};
        irq = 1'b1;
        for (int k = 0; k < 6; k++) begin
            eval();
            n_tests++;
            if (dut_ctrl !== ec[k] || state_o !== es[k]) begin
                n_fail++;
                $display("FAIL irq_seq[%0d]: ctrl=%b state=%0d expected %b/%0d", k, dut_ctrl, state_o, ec[k], es[k]);
            end
            adv();
        end
        irq = 1'b0;
        eval(); adv();
    endtask

    task automatic test_irq_during_ret();
        logic [2:0] es [9];
        logic [5:0] ec [9];
        es = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd0, 3'd2, 3'd3, 3'd3, 3'd0};
        ec = '{6'b100000, 6'b101000, 6'b101000, 6'b101000, 6'b101000,
               6'b101001, 6'b100010, 6'b100010, 6'b000000};
        id_is_ret = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k == 1) begin id_is_ret = 1'b0; irq = 1'b1; end
            eval();
            n_tests++;
            if (dut_ctrl !== ec[k] || state_o !== es[k]) begin
                n_fail++;
                $display("FAIL irq_in_ret[%0d]: ctrl=%b state=%0d expected %b/%0d", k, dut_ctrl, state_o, ec[k], es[k]);
            end
            adv();
        end
        irq = 1'b0;
        eval(); adv();
    endtask

    task automatic test_reset_abort();
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                id_is_ret = 1'b1; eval(); adv(); clr_in();
                eval(); adv();
            end else begin
                irq = 1'b1;
                for (int k = 0; k < 3; k++) begin eval(); adv(); end
            end
            rst = 1'b1; irq = 1'b0;
            eval();
            n_tests++;
            if (dut_ctrl !== 6'b000000) begin
                n_fail++; $display("FAIL abort_rst_ctrl[%0d]: ctrl=%b expected 000000", pass, dut_ctrl);
            end
            adv();
            rst = 1'b0;
            for (int k = 0; k < 3; k++) begin
                eval();
                n_tests++;
                if (dut_ctrl !== 6'b000000 || state_o !== 3'd0) begin
                    n_fail++;
                    $display("FAIL abort_after[%0d.%0d]: ctrl=%b state=%0d expected 000000/0", pass, k, dut_ctrl, state_o);
                end
                adv();
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst             = ($urandom_range(0, 99) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            id_is_ret       = ($urandom_range(0, 9) == 0);
            ex_MemRead      = 1'($urandom_range(0, 1));
            ex_RegWrite     = 1'($urandom_range(0, 1));
            id_uses_ra      = 1'($urandom_range(0, 1));
            id_uses_rb      = 1'($urandom_range(0, 1));
            ex_rd           = 2'($urandom_range(0, 3));
            id_ra           = 2'($urandom_range(0, 3));
            id_rb           = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) irq = ~irq;
            eval();
            n_tests++;
            if (dut_ctrl !== m_ctrl || state_o !== 3'(m_mode) || stall_cnt !== 8'(m_cnt)) begin
                n_fail++;
                $display("FAIL random[%0d]: ctrl=%b state=%0d cnt=%0d expected ctrl=%b state=%0d cnt=%0d",
                         i, dut_ctrl, state_o, stall_cnt, m_ctrl, m_mode, m_cnt);
            end
            adv();
        end
        rst = 1'b0; irq = 1'b0; clr_in();
        eval(); adv();
    endtask

    task automatic test_saturation();
        rst = 1'b1; eval(); adv(); rst = 1'b0;
        ex_MemRead = 1'b1; ex_RegWrite = 1'b1; ex_rd = 2'd2; id_uses_rb = 1'b1; id_rb = 2'd2;
        for (int i = 0; i < 300; i++) begin
            eval();
            if (i == 200 || i == 255 || i == 299) begin
                n_tests++;
                if (stall_cnt !== ((i < 255) ? 8'(i) : 8'd255) || dut_ctrl !== 6'b110010) begin
                    n_fail++;
                    $display("FAIL sat_cnt[%0d]: cnt=%0d ctrl=%b expected cnt=%0d ctrl=110010",
                             i, stall_cnt, dut_ctrl, (i < 255) ? i : 255);
                end
            end
            adv();
        end
        eval();
        n_tests++;
        if (stall_cnt !== 8'd255) begin
            n_fail++; $display("FAIL sat_final: cnt=%0d expected 255", stall_cnt);
        end
        rst = 1'b1;
        eval();
        n_tests++;
        if (dut_ctrl !== 6'b000000) begin
            n_fail++; $display("FAIL sat_rst_ctrl: ctrl=%b expected 000000", dut_ctrl);
        end
        adv();
        rst = 1'b0;
        clr_in();
        eval();
        n_tests++;
        if (stall_cnt !== 8'd0 || state_o !== 3'd0 || dut_ctrl !== 6'b000000) begin
            n_fail++;
            $display("FAIL sat_after_rst: cnt=%0d state=%0d ctrl=%b expected 0/0/000000", stall_cnt, state_o, dut_ctrl);
        end
        adv();
    endtask

    initial begin
        rst = 1'b1; irq = 1'b0;
        clr_in();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch_priority();
        test_ret();
        test_interrupt();
        test_irq_during_ret();
        test_reset_abort();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_ra  in  2  ra address of the instruction in ID
- id_rb  in  2  rb address of the instruction in ID
- id_uses_ra  in  1  ID instruction reads ra
- id_uses_rb  in  1  ID instruction reads rb
- id_is_ret  in  1  RET or RTI decoded in ID
- ex_MemRead  in  1  MemRead of the instruction in EX
- ex_RegWrite  in  1  RegWrite of the instruction in EX
- ex_rd  in  2  destination register of the instruction in EX
- ex_branch_taken  in  1  branch, CALL, RET or RTI redirect resolved in EX
- irq  in  1  external interrupt request, level
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold the IF/ID register
- if_id_flush  out  1  clear the IF/ID register
- id_ex_flush  out  1  drive the ID/EX register flush input
- id_ex_bubble  out  1  drive the ID/EX register inject_bubble input
- int_signal  out  1  interrupt pseudo-op marker into ID/EX
- state_o  out  3  current FSM state
- stall_cnt  out  8  saturating count of stalled cycles
REQ-002 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-003 SHALL implement the FSM states RUN=0, RET_WAIT=1, INT_ENTRY=2, INT_DRAIN=3, and SHALL present the current state on state_o.
REQ-004 SHALL make all control outputs combinational from the registered state, the registered counters and the current inputs (zero-cycle response).
REQ-005 SHALL hold the outputs at default 0 in any cycle where no rule below asserts them.
REQ-006 SHALL register an internal irq_pend bit:
- set on a 0->1 edge of irq (irq delayed one cycle)
- cleared on the cycle that leaves INT_ENTRY
- a set and a clear in the same cycle results in clear
REQ-007 SHALL, in RUN, apply these rules in priority order, highest first:
- (a) ex_branch_taken: if_id_flush=1, id_ex_flush=1; next state RUN.
- (b) irq_pend and id_is_ret=0: pc_stall=1, if_id_flush=1; next state INT_ENTRY.
- (c) Load-use: ex_MemRead and ex_RegWrite and ((id_uses_ra and id_ra==ex_rd) or (id_uses_rb and id_rb==ex_rd)). Assert pc_stall=1, if_id_stall=1, id_ex_bubble=1; stay in RUN.
- (d) id_is_ret: pc_stall=1; load wait_cnt=2; next state RET_WAIT.
REQ-008 SHALL, in RET_WAIT:
- each cycle: pc_stall=1, if_id_flush=1, and wait_cnt decrements by 1
- on ex_branch_taken: additionally id_ex_flush=1; next state RUN, which overrides the count
- otherwise: next state RUN when wait_cnt==0 at the start of the cycle
REQ-009 SHALL, in INT_ENTRY (exactly one cycle):
- assert int_signal=1, pc_stall=1, if_id_flush=1
- load wait_cnt=1; next state INT_DRAIN
REQ-010 SHALL, in INT_DRAIN:
- each cycle: pc_stall=1, id_ex_bubble=1, and wait_cnt decrements
- next state RUN when wait_cnt==0 at the start of the cycle
- ex_branch_taken additionally asserts if_id_flush=1 and id_ex_flush=1, without leaving the state early
REQ-011 SHALL never assert int_signal outside INT_ENTRY.
REQ-012 SHALL never assert id_ex_bubble in a cycle where id_ex_flush=1, because flush wins.
REQ-013 SHALL treat wait_cnt as 2 bits.
REQ-014 SHALL increment stall_cnt by 1 in every cycle with pc_stall=1, saturating at 255 with no wrap.
REQ-015 SHALL treat irq rising while in RET_WAIT or INT_DRAIN as pending, and service it only after returning to RUN.

Reset
REQ-016 SHALL, with rst=1 at a clock edge, force:
- state=RUN, wait_cnt=0, irq_pend=0, irq delay register=0, stall_cnt=0
REQ-017 SHALL, while rst=1, drive all control outputs to 0 regardless of inputs.
REQ-018 SHALL let reset asserted mid-RET_WAIT or mid-INT_DRAIN abort the sequence, with no residual stall after rst falls.

Verification
REQ-019 Load-use: ex_MemRead=1, ex_RegWrite=1, ex_rd=2, id_uses_rb=1, id_rb=2 -> same cycle pc_stall=if_id_stall=id_ex_bubble=1; state stays 0; stall_cnt 0->1.
REQ-020 Branch beats load-use: the REQ-019 inputs plus ex_branch_taken=1 -> if_id_flush=id_ex_flush=1, id_ex_bubble=0, pc_stall=0.
REQ-021 RET: id_is_ret=1 in RUN -> state_o sequence 1,1,1,0, with pc_stall=1 for 4 cycles in total. Repeat with ex_branch_taken=1 on the 2nd RET_WAIT cycle -> RUN on the next cycle.
REQ-022 Interrupt: irq 0->1 in RUN -> state_o 2 then 3,3 then 0; int_signal=1 for exactly one cycle; id_ex_bubble=1 for 2 cycles.
REQ-023 irq rising during RET_WAIT -> INT_ENTRY occurs on the first RUN cycle after the RET sequence.
REQ-024 Saturation and reset: 300 consecutive load-use cycles -> stall_cnt=255. Then rst=1 for one cycle -> stall_cnt=0, state_o=0.
